// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM loader / SDRAM arbiter slice.
// FIFO entries are packed vectors laid out as {addr[ADDR_W-1:0], data[15:0], be[1:0]}.
package rom_load_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LWR,
        ARB_CWR
    } arb_state_t;

    localparam int unsigned ROM_SIZE_W = 24;
    localparam int unsigned LDR_DATA_W = 16;
    localparam int unsigned LDR_BE_W   = 2;

    function automatic int unsigned entry_w(input int unsigned addr_w);
        return addr_w + LDR_DATA_W + LDR_BE_W;
    endfunction

endpackage

// File: rtl/rom_wr_fifo.sv
// Loader write queue: synchronous FIFO, head entry stays valid until popped on mem_ack.
// Pushes while full and pops while empty are ignored.
module rom_wr_fifo
    import rom_load_pkg::*;
#(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             last
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign last  = (count == (PTR_W+1)'(1));

endmodule

// File: rtl/rom_load_arbiter.sv
// Packs the ROM byte stream into 16-bit SDRAM writes and arbitrates the single
// SDRAM port between those loader writes and the emulation core.
module rom_load_arbiter
    import rom_load_pkg::*;
#(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rom_loading,
    input  logic [7:0]            rom_do,
    input  logic                  rom_do_valid,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [15:0]           core_din,
    input  logic [1:0]            core_be,
    output logic                  core_ack,
    output logic [15:0]           core_dout,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_din,
    output logic [1:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_dout,
    output logic                  loading_busy,
    output logic [ROM_SIZE_W-1:0] rom_size,
    output logic                  overflow
);

    localparam int unsigned ENTRY_W = entry_w(ADDR_W);

    // packer state
    logic                  rom_loading_q;
    logic                  pending_q;
    logic [7:0]            lo_q;
    logic [ADDR_W-1:0]     waddr_q;

    logic                  rise, fall, byte_ok;
    logic                  pend_base, pend_n;
    logic [7:0]            lo_base, lo_n;
    logic [ADDR_W-1:0]     addr_base, addr_n;
    logic [ROM_SIZE_W-1:0] size_base, size_n;
    logic                  ovf_n, busy_n;
    logic                  want_push, push, pop;
    logic [ENTRY_W-1:0]    push_entry, fifo_head;
    logic                  fifo_empty, fifo_full, fifo_last, fifo_drains;

    // arbiter state
    arb_state_t            state_q, state_d;
    logic                  mem_req_d, mem_we_d, core_ack_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [15:0]           mem_din_d, core_dout_d;
    logic [1:0]            mem_be_d;

    assign rise    = rom_loading & ~rom_loading_q;
    assign fall    = ~rom_loading & rom_loading_q;
    assign byte_ok = rom_do_valid & (rom_loading | rom_loading_q);

    // A rising edge clears the counters first; a byte in the same cycle then lands in the fresh load.
    // On a falling edge the byte is packed before the flush, so at most one push per cycle results.
    always_comb begin
        pend_base  = rise ? 1'b0 : pending_q;
        lo_base    = rise ? 8'h00 : lo_q;
        addr_base  = rise ? '0 : waddr_q;
        size_base  = rise ? '0 : rom_size;
        ovf_n      = rise ? 1'b0 : overflow;
        pend_n     = pend_base;
        lo_n       = lo_base;
        addr_n     = addr_base;
        size_n     = size_base;
        want_push  = 1'b0;
        push_entry = '0;
        if (byte_ok) begin
            size_n = size_base + ROM_SIZE_W'(1);
            if (pend_base) begin
                want_push  = 1'b1;
                push_entry = {addr_base, rom_do, lo_base, 2'b11};
                pend_n     = 1'b0;
            end else begin
                lo_n   = rom_do;
                pend_n = 1'b1;
            end
        end
        if (fall && pend_n) begin
            want_push  = 1'b1;
            push_entry = {addr_base, 8'h00, lo_n, 2'b01};
            pend_n     = 1'b0;
        end
        if (want_push) begin
            if (fifo_full) ovf_n = 1'b1;
            else           addr_n = addr_base + ADDR_W'(1);
        end
    end

    assign push        = want_push & ~fifo_full;
    assign fifo_drains = ~push & (fifo_empty | (fifo_last & pop));

    always_comb begin
        busy_n = loading_busy;
        if (rise)
            busy_n = 1'b1;
        else if (loading_busy && !rom_loading && !pend_n && fifo_drains)
            busy_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_loading_q <= 1'b0;
            pending_q     <= 1'b0;
            lo_q          <= '0;
            waddr_q       <= '0;
            rom_size      <= '0;
            overflow      <= 1'b0;
            loading_busy  <= 1'b0;
        end else begin
            rom_loading_q <= rom_loading;
            pending_q     <= pend_n;
            lo_q          <= lo_n;
            waddr_q       <= addr_n;
            rom_size      <= size_n;
            overflow      <= ovf_n;
            loading_busy  <= busy_n;
        end
    end

    rom_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .last      (fifo_last)
    );

    // core_ack blocks re-entry for one cycle so a core still holding req after its ack is not served twice
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_din_d   = mem_din;
        mem_be_d    = mem_be;
        core_ack_d  = 1'b0;
        core_dout_d = core_dout;
        pop         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!fifo_empty) begin
                    state_d    = ARB_LWR;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = fifo_head[ENTRY_W-1 -: ADDR_W];
                    mem_din_d  = fifo_head[17:2];
                    mem_be_d   = fifo_head[1:0];
                end else if (core_req && !loading_busy && !core_ack) begin
                    state_d    = ARB_CWR;
                    mem_req_d  = 1'b1;
                    mem_we_d   = core_we;
                    mem_addr_d = core_addr;
                    mem_din_d  = core_din;
                    mem_be_d   = core_be;
                end
            end
            ARB_LWR: begin
                if (mem_ack) begin
                    pop       = 1'b1;
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            ARB_CWR: begin
                if (mem_ack) begin
                    core_ack_d  = 1'b1;
                    core_dout_d = mem_dout;
                    state_d     = ARB_IDLE;
                    mem_req_d   = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_be    <= '0;
            core_ack  <= 1'b0;
            core_dout <= '0;
        end else begin
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_din   <= mem_din_d;
            mem_be    <= mem_be_d;
            core_ack  <= core_ack_d;
            core_dout <= core_dout_d;
        end
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Scoreboard bench: expected SDRAM accesses are queued as stimulus is driven and
// checked by the SDRAM responder as each access is acknowledged.
module tb_rom_load_arbiter;

    localparam int unsigned AW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          rom_loading, rom_do_valid;
    logic [7:0]    rom_do;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [15:0]   core_din;
    logic [1:0]    core_be;
    logic          core_ack;
    logic [15:0]   core_dout;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_be;
    logic          mem_ack;
    logic [15:0]   mem_dout;
    logic          loading_busy;
    logic [23:0]   rom_size;
    logic          overflow;

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned mem_lat = 0;
    bit          hold_ack = 1'b0;
    int unsigned wait_cnt = 0;

    always #5 clk = ~clk;

    rom_load_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_loading  (rom_loading),
        .rom_do       (rom_do),
        .rom_do_valid (rom_do_valid),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_din     (core_din),
        .core_be      (core_be),
        .core_ack     (core_ack),
        .core_dout    (core_dout),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_dout     (mem_dout),
        .loading_busy (loading_busy),
        .rom_size     (rom_size),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_model(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
        exp_t e;
        e.we = 1'b1; e.addr = a; e.data = d; e.be = be;
        exp_q.push_back(e);
    endtask

    // SDRAM model: acks mem_req after mem_lat wait cycles and scores the access
    always begin
        exp_t e;
        tick();
        mem_ack = 1'b0;
        if (reset || !mem_req || hold_ack) begin
            wait_cnt = 0;
        end else if (wait_cnt < mem_lat) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            mem_ack  = 1'b1;
            mem_dout = rd_model(mem_addr);
            if (exp_q.size() == 0) begin
                check("mem_unexpected_access", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("mem_we", mem_we, e.we);
                check("mem_addr", mem_addr, e.addr);
                if (e.we) begin
                    check("mem_din", mem_din, e.data);
                    check("mem_be", mem_be, e.be);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rom_do = b;
        rom_do_valid = 1'b1;
        tick();
        rom_do_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!loading_busy && exp_q.size() == 0 && !mem_req) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1);
    endtask

    task automatic core_access(input bit we, input logic [AW-1:0] a, input logic [15:0] d,
                               input bit check_free);
        exp_t e;
        bit acked = 1'b0;
        bit fast;
        int since_free = 0;
        e.we = we; e.addr = a; e.data = d; e.be = 2'b11;
        if (!check_free) exp_q.push_back(e);
        core_we = we; core_addr = a; core_din = d; core_be = 2'b11; core_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (loading_busy) since_free = 0;
            else since_free++;
            if (core_ack) begin
                acked = 1'b1;
                break;
            end
        end
        core_req = 1'b0;
        check("core_ack_seen", acked, 1);
        if (acked) begin
            if (!we) check("core_dout", core_dout, rd_model(a));
            if (check_free) begin
                fast = (since_free <= 3);
                check("core_busy_at_ack", loading_busy, 0);
                check("core_served_within_3", fast, 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit seen;
        logic [7:0] b;
        reset = 1'b1; rom_loading = 1'b0; rom_do = '0; rom_do_valid = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_din = '0; core_be = '0;
        mem_ack = 1'b0; mem_dout = '0;
        repeat (3) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_core_ack", core_ack, 0);
        check("rst_busy", loading_busy, 0);
        check("rst_rom_size", rom_size, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick();

        // 1: even load
        expect_wr(22'd0, 16'h2211, 2'b11);
        expect_wr(22'd1, 16'h4433, 2'b11);
        rom_loading = 1'b1;
        tick();
        check("t1_busy_rise", loading_busy, 1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        rom_loading = 1'b0;
        wait_drain("t1_drain");
        check("t1_rom_size", rom_size, 4);
        check("t1_overflow", overflow, 0);

        // 2: odd load, last byte arrives in the same cycle rom_loading falls
        expect_wr(22'd0, 16'hBBAA, 2'b11);
        expect_wr(22'd1, 16'h00CC, 2'b01);
        rom_loading = 1'b1;
        tick();
        send_byte(8'hAA); send_byte(8'hBB);
        rom_loading = 1'b0;
        send_byte(8'hCC);
        wait_drain("t2_drain");
        check("t2_rom_size", rom_size, 3);

        // 3: core read with 3-cycle SDRAM latency, load starts while it is in flight
        mem_lat = 3;
        fork
            core_access(1'b0, 22'd5, 16'h0000, 1'b0);
            begin
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    tick();
                    if (mem_req) begin seen = 1'b1; break; end
                end
                check("t3_core_in_flight", seen, 1);
                expect_wr(22'd0, 16'h0201, 2'b11);
                rom_loading = 1'b1;
                tick();
                send_byte(8'h01); send_byte(8'h02);
                rom_loading = 1'b0;
            end
        join
        wait_drain("t3_drain");
        check("t3_rom_size", rom_size, 2);
        mem_lat = 0;

        // 4: SDRAM stalled while 12 bytes stream; words 4 and 5 are dropped
        hold_ack = 1'b1;
        rom_loading = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h10 + 2*i);
            expect_wr(22'(i), {b + 8'd1, b}, 2'b11);
        end
        for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
        rom_loading = 1'b0;
        repeat (26) tick();
        check("t4_overflow_held", overflow, 1);
        check("t4_rom_size", rom_size, 12);
        check("t4_busy_held", loading_busy, 1);
        hold_ack = 1'b0;
        wait_drain("t4_drain");
        check("t4_overflow_sticky", overflow, 1);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: core write held off for the whole load
        expect_wr(22'd0, 16'h6655, 2'b11);
        expect_wr(22'd1, 16'h8877, 2'b11);
        rom_loading = 1'b1;
        tick(); tick();
        check("t5_overflow_cleared", overflow, 0);
        fork
            core_access(1'b1, 22'h100, 16'hBEEF, 1'b1);
            begin
                send_byte(8'h55); send_byte(8'h66);
                tick();
                send_byte(8'h77); send_byte(8'h88);
                expect_wr(22'h100, 16'hBEEF, 2'b11);
                rom_loading = 1'b0;
            end
        join
        wait_drain("t5_drain");

        // 6: reset in the middle of a stalled load
        hold_ack = 1'b1;
        rom_loading = 1'b1;
        tick();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        check("t6_mem_req_before", mem_req, 1);
        reset = 1'b1;
        rom_loading = 1'b0;
        tick();
        check("t6_mem_req", mem_req, 0);
        check("t6_busy", loading_busy, 0);
        check("t6_rom_size", rom_size, 0);
        check("t6_overflow", overflow, 0);
        exp_q.delete();
        reset = 1'b0;
        hold_ack = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (mem_req) seen = 1'b1;
        end
        check("t6_fifo_empty", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
